// File: rtl/temp_average_div.sv
// temp_average_div
// -----------------------------------------------------------------------------
// Averages one frame of 8-bit sensor temperatures. A frame begins with
// start_i. Each valid, enabled sample is added to a 16-bit sum, up to
// MAX_ACTIVE samples. Enabled samples beyond that limit are dropped and set a
// sticky overflow flag. The sample marked sample_last_i ends the frame. The sum
// is then divided by the number of accepted samples. The divider is a 16-step
// restoring divider that produces one quotient bit per cycle, MSB first. The
// quotient, remainder, count and status flags are registered as the block
// enters DONE. They hold their values until the next DONE.
//
// Ports
//   clk_i               clock
//   rst_n_i             synchronous active-low reset
//   start_i             starts a new frame (honoured in IDLE only)
//   sample_valid_i      a sample is present this cycle
//   sample_en_i         the presented sensor is active
//   sample_data_i[7:0]  sensor temperature, unsigned
//   sample_last_i       the presented sample closes the frame
//   temp_Q_o[15:0]      quotient  sum / active count
//   temp_R_o[15:0]      remainder sum % active count
//   active_sensors_nr_o number of enabled samples accumulated
//   done_o              high for the single DONE cycle
//   busy_o              high in ACCUM and DIVIDE
//   no_sensor_o         last frame had zero enabled samples
//   overflow_o          last frame had more than MAX_ACTIVE enabled samples
// -----------------------------------------------------------------------------
module temp_average_div #(
    parameter int MAX_ACTIVE = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        sample_valid_i,
    input  logic        sample_en_i,
    input  logic [7:0]  sample_data_i,
    input  logic        sample_last_i,
    output logic [15:0] temp_Q_o,
    output logic [15:0] temp_R_o,
    output logic [7:0]  active_sensors_nr_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        no_sensor_o,
    output logic        overflow_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_DIVIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0] MAX_CNT = 8'(MAX_ACTIVE);

    logic [1:0]  state_reg, state_next;
    logic [15:0] sum_reg, sum_next;
    logic [7:0]  count_reg, count_next;
    logic        ovf_reg, ovf_next;

    // Divider working registers. quot_reg starts out holding the dividend.
    // Dividend bits are shifted out of its top while quotient bits are
    // shifted in at its bottom.
    logic [15:0] quot_reg, quot_next;
    logic [15:0] rem_reg, rem_next;
    logic [3:0]  step_reg, step_next;

    logic [15:0] q_out_reg, q_out_next;
    logic [15:0] r_out_reg, r_out_next;
    logic [7:0]  nr_out_reg, nr_out_next;
    logic        nos_out_reg, nos_out_next;
    logic        ovf_out_reg, ovf_out_next;

    // One restoring-division step. The partial remainder is always below the
    // 8-bit divisor, so after the shift it still fits in 16 bits. The 17th
    // bit only keeps the comparison exact.
    logic [16:0] rem_shift;
    logic        step_fits;
    logic [15:0] rem_diff;
    logic [15:0] rem_step;
    logic [15:0] quot_step;

    always_comb begin
        rem_shift = {rem_reg, quot_reg[15]};
        step_fits = (rem_shift >= {9'd0, count_reg});
        rem_diff  = rem_shift[15:0] - {8'd0, count_reg};
        rem_step  = step_fits ? rem_diff : rem_shift[15:0];
        quot_step = {quot_reg[14:0], step_fits};
    end

    always_comb begin
        state_next   = state_reg;
        sum_next     = sum_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        quot_next    = quot_reg;
        rem_next     = rem_reg;
        step_next    = step_reg;
        q_out_next   = q_out_reg;
        r_out_next   = r_out_reg;
        nr_out_next  = nr_out_reg;
        nos_out_next = nos_out_reg;
        ovf_out_next = ovf_out_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    sum_next   = 16'd0;
                    count_next = 8'd0;
                    ovf_next   = 1'b0;
                    state_next = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (sample_valid_i && sample_en_i) begin
                    if (count_reg < MAX_CNT) begin
                        sum_next   = sum_reg + {8'd0, sample_data_i};
                        count_next = count_reg + 8'd1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                if (sample_valid_i && sample_last_i) begin
                    // Load the dividend with the sum that includes the closing
                    // sample, so DIVIDE can start stepping on its first cycle.
                    quot_next  = sum_next;
                    rem_next   = 16'd0;
                    step_next  = 4'd0;
                    state_next = ST_DIVIDE;
                end
            end

            ST_DIVIDE: begin
                if (count_reg == 8'd0) begin
                    q_out_next   = 16'd0;
                    r_out_next   = 16'd0;
                    nr_out_next  = 8'd0;
                    nos_out_next = 1'b1;
                    ovf_out_next = ovf_reg;
                    state_next   = ST_DONE;
                end else begin
                    quot_next = quot_step;
                    rem_next  = rem_step;
                    step_next = step_reg + 4'd1;
                    if (step_reg == 4'd15) begin
                        q_out_next   = quot_step;
                        r_out_next   = rem_step;
                        nr_out_next  = count_reg;
                        nos_out_next = 1'b0;
                        ovf_out_next = ovf_reg;
                        state_next   = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            sum_reg     <= 16'd0;
            count_reg   <= 8'd0;
            ovf_reg     <= 1'b0;
            quot_reg    <= 16'd0;
            rem_reg     <= 16'd0;
            step_reg    <= 4'd0;
            q_out_reg   <= 16'd0;
            r_out_reg   <= 16'd0;
            nr_out_reg  <= 8'd0;
            nos_out_reg <= 1'b0;
            ovf_out_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sum_reg     <= sum_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            quot_reg    <= quot_next;
            rem_reg     <= rem_next;
            step_reg    <= step_next;
            q_out_reg   <= q_out_next;
            r_out_reg   <= r_out_next;
            nr_out_reg  <= nr_out_next;
            nos_out_reg <= nos_out_next;
            ovf_out_reg <= ovf_out_next;
        end
    end

    assign temp_Q_o            = q_out_reg;
    assign temp_R_o            = r_out_reg;
    assign active_sensors_nr_o = nr_out_reg;
    assign no_sensor_o         = nos_out_reg;
    assign overflow_o          = ovf_out_reg;
    assign done_o              = (state_reg == ST_DONE);
    assign busy_o              = (state_reg == ST_ACCUM) || (state_reg == ST_DIVIDE);

endmodule

// File: tb/tb_temp_average_div.sv
// Testbench for temp_average_div.
// Frames are described as queues of (data, enable) pairs. The expected
// results come from plain integer arithmetic over the queue. The check
// "latency N" counts clock edges from the edge that accepts the last sample
// to the first edge after which done_o is high.
module tb_temp_average_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic        en;
    logic [7:0]  data;
    logic        last;
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  nr;
    logic        done;
    logic        busy;
    logic        nos;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fd[$];
    bit         fe[$];

    always #5 clk = ~clk;

    temp_average_div #(.MAX_ACTIVE(255)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .start_i             (start),
        .sample_valid_i      (valid),
        .sample_en_i         (en),
        .sample_data_i       (data),
        .sample_last_i       (last),
        .temp_Q_o            (q),
        .temp_R_o            (r),
        .active_sensors_nr_o (nr),
        .done_o              (done),
        .busy_o              (busy),
        .no_sensor_o         (nos),
        .overflow_o          (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: average of the enabled samples, capped at 255 accepted ones.
    task automatic model(output int eq, output int er, output int enr,
                         output int enos, output int eovf);
        int s;
        int c;
        s = 0;
        c = 0;
        eovf = 0;
        foreach (fe[i]) begin
            if (fe[i]) begin
                if (c < 255) begin
                    s += int'(fd[i]);
                    c++;
                end else begin
                    eovf = 1;
                end
            end
        end
        enr  = c;
        enos = (c == 0) ? 1 : 0;
        eq   = (c == 0) ? 0 : s / c;
        er   = (c == 0) ? 0 : s % c;
    endtask

    task automatic send_frame(input int start_at, input bit gaps);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_accum", 32'(busy), 1);
        foreach (fd[i]) begin
            if (gaps) begin
                // Idle cycles carrying junk data, and sometimes a stray last
                // flag without valid. All of it must be ignored.
                while ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    last  = 1'($urandom_range(0, 1));
                    en    = 1'($urandom_range(0, 1));
                    data  = 8'($urandom);
                    tick();
                end
            end
            valid = 1'b1;
            en    = fe[i];
            data  = fd[i];
            last  = (i == fd.size() - 1);
            start = (i == start_at);
            tick();
        end
        valid = 1'b0;
        last  = 1'b0;
        en    = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit start_in_div);
        int eq, er, enr, enos, eovf;
        int lat;
        int exp_lat;
        int extra_done;
        model(eq, er, enr, enos, eovf);
        exp_lat = (enr == 0) ? 1 : 16;
        chk({tag, "_busy_div"}, 32'(busy), 1);
        lat = 0;
        do begin
            if (start_in_div && lat == 3) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end while (done !== 1'b1 && lat < 40);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_q"}, 32'(q), eq);
        chk({tag, "_r"}, 32'(r), er);
        chk({tag, "_nr"}, 32'(nr), enr);
        chk({tag, "_no_sensor"}, 32'(nos), enos);
        chk({tag, "_overflow"}, 32'(ovf), eovf);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        // The outputs hold. No second done_o pulse and no restarted frame follow.
        extra_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        chk({tag, "_single_done_idle"}, extra_done, 0);
        chk({tag, "_q_hold"}, 32'(q), eq);
        chk({tag, "_r_hold"}, 32'(r), er);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q"}, 32'(q), 0);
        chk({tag, "_r"}, 32'(r), 0);
        chk({tag, "_nr"}, 32'(nr), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_no_sensor"}, 32'(nos), 0);
        chk({tag, "_overflow"}, 32'(ovf), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        en    = 1'b0;
        data  = 8'd0;
        last  = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Three enabled samples.
        fd = '{8'd20, 8'd21, 8'd22};
        fe = '{1, 1, 1};
        send_frame(-1, 1'b0);
        finish_frame("avg3", 1'b0);

        // A disabled sample in the middle is excluded.
        fd = '{8'd20, 8'd99, 8'd23};
        fe = '{1, 0, 1};
        send_frame(-1, 1'b0);
        finish_frame("disabled_mid", 1'b0);

        // Every sample disabled.
        fd = '{8'd5, 8'd6, 8'd7};
        fe = '{0, 0, 0};
        send_frame(-1, 1'b0);
        finish_frame("no_sensor", 1'b0);

        // 256 enabled samples of 255. The last one exceeds MAX_ACTIVE.
        fd.delete();
        fe.delete();
        for (int i = 0; i < 256; i++) begin
            fd.push_back(8'd255);
            fe.push_back(1'b1);
        end
        send_frame(-1, 1'b0);
        finish_frame("overflow", 1'b0);

        // Reset pulse in the 8th DIVIDE cycle discards the frame.
        fd = '{8'd30, 8'd40, 8'd50};
        fe = '{1, 1, 1};
        send_frame(-1, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("mid_div_reset");
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        chk("mid_div_reset_no_done", seen_done, 0);
        fd = '{8'd18, 8'd19};
        fe = '{1, 1};
        send_frame(-1, 1'b0);
        finish_frame("after_reset", 1'b0);

        // start_i pulsed during ACCUM and during DIVIDE is ignored.
        fd = '{8'd100, 8'd7, 8'd33, 8'd250, 8'd1};
        fe = '{1, 1, 0, 1, 1};
        send_frame(2, 1'b0);
        finish_frame("start_ignored", 1'b1);

        // Randomised frames with idle gaps.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 20);
            fd.delete();
            fe.delete();
            for (int i = 0; i < n; i++) begin
                fd.push_back(8'($urandom));
                fe.push_back($urandom_range(0, 9) < 7);
            end
            send_frame(-1, 1'b1);
            finish_frame($sformatf("rand%0d", f), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/temp_average_div.md
TEMP_AVERAGE_DIV -- requirements
Module: temp_average_div

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i is the single clock and rst_n_i is the reset, sampled on the rising edge of clk_i.
REQ-002 The block SHALL have parameter MAX_ACTIVE, default 255, giving the maximum number of enabled samples accumulated per frame (legal range 1..255).
REQ-003 The block SHALL have these ports:
- clk_i  input  1  clock
- rst_n_i  input  1  synchronous active-low reset
- start_i  input  1  starts a new frame (single-cycle pulse)
- sample_valid_i  input  1  a sample is present this cycle
- sample_en_i  input  1  the presented sensor is active
- sample_data_i  input  8  sensor temperature, unsigned
- sample_last_i  input  1  the presented sample is the last of the frame
- temp_Q_o  output  16  quotient of sum / active count
- temp_R_o  output  16  remainder of sum / active count
- active_sensors_nr_o  output  8  count of enabled samples accumulated
- done_o  output  1  one-cycle pulse when the outputs update
- busy_o  output  1  high in ACCUM and DIVIDE
- no_sensor_o  output  1  the last frame had zero enabled samples
- overflow_o  output  1  the last frame exceeded MAX_ACTIVE enabled samples

Function
REQ-004 The block SHALL implement the states IDLE, ACCUM, DIVIDE and DONE.
REQ-005 In IDLE, start_i=1 SHALL clear sum (16 bit) and count (8 bit) and go to ACCUM on the next edge. All other inputs are ignored in IDLE.
REQ-006 In ACCUM, each cycle with sample_valid_i=1 and sample_en_i=1 SHALL add sample_data_i to sum and increment count, but only while count < MAX_ACTIVE.
REQ-007 In ACCUM, an enabled valid sample arriving with count = MAX_ACTIVE SHALL be dropped, and SHALL set a sticky frame-overflow flag.
REQ-008 In ACCUM, a valid sample with sample_en_i=0 SHALL be ignored, and its sample_data_i value SHALL NOT affect sum.
REQ-009 In ACCUM, sample_last_i=1 together with sample_valid_i=1 SHALL end the frame, after that sample is processed, and SHALL go to DIVIDE.
REQ-010 In ACCUM, sample_last_i without sample_valid_i SHALL be ignored.
REQ-011 start_i asserted outside IDLE SHALL be ignored; it does not restart the frame.
REQ-012 DIVIDE SHALL perform a 16-cycle restoring division of the 16-bit sum by the zero-extended count, one quotient bit per cycle, MSB first.
REQ-013 If count = 0 on entry to DIVIDE, the division SHALL be skipped: Q=0, R=0, and no_sensor result = 1. The block goes to DONE on the next edge.
REQ-014 DONE SHALL last exactly one cycle and SHALL then return to IDLE.
REQ-015 On the edge entering DONE, the block SHALL register temp_Q_o, temp_R_o, active_sensors_nr_o, no_sensor_o and overflow_o. done_o SHALL be 1 during DONE.
REQ-016 The registered outputs SHALL hold their values until the next DONE.
REQ-017 Latency SHALL be as follows:
- last sample accepted at edge N -> done_o high in cycle N+17 for count>0
- for count=0, done_o high in cycle N+2
REQ-018 temp_R_o SHALL always be less than active_sensors_nr_o when count>0.
REQ-019 temp_Q_o*count + temp_R_o SHALL equal sum exactly.
REQ-020 sum SHALL NOT wrap: 255*255 = 65025 fits in 16 bits.
REQ-021 busy_o SHALL be combinational from the state: 1 in ACCUM or DIVIDE, 0 otherwise.

Reset
REQ-022 rst_n_i=0 at any clock edge, including mid-ACCUM or mid-DIVIDE, SHALL force IDLE, clear sum, count and the divider registers, and discard the frame.
REQ-023 After reset, all outputs SHALL be 0: temp_Q_o, temp_R_o, active_sensors_nr_o, done_o, busy_o, no_sensor_o and overflow_o.
REQ-024 The first start_i accepted after reset release SHALL start a clean frame.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Enabled samples 20, 21, 22 (last on 22) -> done_o 17 cycles later; Q=21, R=0, nr=3, no_sensor_o=0.
- Samples 20(en), 99(dis), 23(en, last) -> Q=21, R=1, nr=2; the disabled 99 is excluded.
- Frame with all samples disabled -> done_o 2 cycles after last; Q=0, R=0, nr=0, no_sensor_o=1.
- 256 enabled samples of value 255 with MAX_ACTIVE=255 -> Q=255, R=0, nr=255, overflow_o=1.
- rst_n_i=0 for one cycle in the 8th DIVIDE cycle -> no done_o; all outputs 0; a new frame of 18, 19 gives Q=18, R=1, nr=2.
- start_i pulsed during ACCUM and during DIVIDE -> ignored; the result matches the original frame, and exactly one done_o pulse occurs.
